rr_mux_arb4: RTL and testbench

- Round-robin arbiter that shares one W-bit 4:1 datapath mux between four requesters.
- Each requester presents data plus a request. The block grants one requester at a time for a bounded burst, drives the mux select, and forwards the selected word to a single consumer over a valid/ready handshake.
- Sits in front of any shared downstream unit (ALU, register-file write port, bus).

---
 rtl/rr_mux_arb4.sv | 107 ++++++++++
 tb/tb_rr_mux_arb4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb4.sv
// rr_mux_arb4: round-robin arbiter sharing one W-bit 4:1 mux between four
// requesters. It grants one requester per burst and forwards the selected
// word over a valid/ready handshake.
module rr_mux_arb4 #(
  parameter int unsigned W     = 8,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   ack,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [1:0]   sel,
  output logic         busy
);

  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] cnt;

  logic [1:0]    pick;
  logic          found;
  logic [1:0]    idx;
  logic          req_sel;
  logic          xfer;
  logic          release_c;

  // Round-robin pick: first requester after the one served last.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Shared datapath mux; the select is honoured in every state.
  always_comb begin
    case (sel)
      2'd3:    o_data = d3;
      2'd2:    o_data = d2;
      2'd1:    o_data = d1;
      default: o_data = d0;
    endcase
  end

  // Handshake decode; a reset cycle never acknowledges the in-flight word.
  always_comb begin
    req_sel   = req[sel];
    o_valid   = (state == GRANT) && req_sel && !rst;
    xfer      = o_valid && o_ready;
    ack       = 4'b0000;
    ack[sel]  = xfer;
    release_c = (xfer && (cnt == CNT_LAST)) || !req_sel;
    busy      = (state == GRANT);
  end

  // Arbitration FSM: grant, count the burst, release with fairness update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            cnt <= CW'(cnt + 1'b1);
          end
          if (release_c) begin
            last  <= sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arb4.sv
// tb_rr_mux_arb4: directed checks of rr_mux_arb4 with BURST=4 and BURST=1.
module tb_rr_mux_arb4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req1;
  logic [7:0] d0, d1, d2, d3;
  logic       o_ready;
  logic       o_ready1;

  logic [3:0] ack, ack1;
  logic [7:0] o_data, o_data1;
  logic       o_valid, o_valid1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_mux_arb4 #(.W(8), .BURST(4)) u4 (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ack(ack), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .sel(sel), .busy(busy)
  );

  rr_mux_arb4 #(.W(8), .BURST(1)) u1 (
    .clk(clk), .rst(rst), .req(req1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ack(ack1), .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1),
    .sel(sel1), .busy(busy1)
  );

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic [3:0] r1);
    rst = 1'b1;
    req = r;
    req1 = r1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0] exp_sel [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; req = 4'b1111; req1 = 4'b0000;
    o_ready = 1'b1; o_ready1 = 1'b1;
    d0 = 8'h11; d1 = 8'h22; d2 = 8'hA5; d3 = 8'h3C;

    // Test 1: reset held two cycles with all requesting.
    for (int i = 0; i < 2; i++) begin
      cyc();
      ck("rst_valid", 32'(o_valid), 32'd0);
      ck("rst_ack",   32'(ack),     32'd0);
      ck("rst_busy",  32'(busy),    32'd0);
      ck("rst_sel",   32'(sel),     32'd0);
      ck("rst_data",  32'(o_data),  32'h11);
    end
    rst = 1'b0;
    #1;
    ck("idle_after_rst_busy",  32'(busy),    32'd0);
    ck("idle_after_rst_valid", 32'(o_valid), 32'd0);
    cyc();
    ck("first_grant_sel",  32'(sel),  32'd0);
    ck("first_grant_busy", 32'(busy), 32'd1);
    ck("first_grant_ack",  32'(ack),  32'b0001);
    ck("first_grant_data", 32'(o_data), 32'h11);

    // Test 2: single requester 2, full bursts of 4 with one bubble.
    do_reset(4'b0100, 4'b0000);
    ck("t2_bubble_valid", 32'(o_valid), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      ck("t2_sel",   32'(sel),     32'd2);
      ck("t2_data",  32'(o_data),  32'hA5);
      ck("t2_ack",   32'(ack),     32'b0100);
      ck("t2_valid", 32'(o_valid), 32'd1);
      cyc();
    end
    ck("t2_rel_busy",  32'(busy),    32'd0);
    ck("t2_rel_ack",   32'(ack),     32'd0);
    ck("t2_rel_valid", 32'(o_valid), 32'd0);
    ck("t2_rel_sel",   32'(sel),     32'd2);
    cyc();
    ck("t2_regrant_sel", 32'(sel), 32'd2);
    ck("t2_regrant_ack", 32'(ack), 32'b0100);

    // Test 3: BURST=1, all requesting, one ack per grant in rotation.
    do_reset(4'b0000, 4'b1111);
    cyc();
    for (int i = 0; i < 5; i++) begin
      ck("t3_sel",   32'(sel1),    32'(exp_sel[i]));
      ck("t3_ack",   32'(ack1),    32'(4'b0001 << exp_sel[i]));
      ck("t3_busy",  32'(busy1),   32'd1);
      ck("t3_valid", 32'(o_valid1), 32'd1);
      cyc();
      ck("t3_idle_busy", 32'(busy1), 32'd0);
      ck("t3_idle_ack",  32'(ack1),  32'd0);
      cyc();
    end
    req1 = 4'b0000;

    // Test 4: requester 1 stalled by backpressure, then drains the full burst.
    do_reset(4'b0010, 4'b0000);
    o_ready = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      d1 = 8'(8'h40 + i);
      #1;
      ck("t4_stall_sel",   32'(sel),     32'd1);
      ck("t4_stall_valid", 32'(o_valid), 32'd1);
      ck("t4_stall_ack",   32'(ack),     32'd0);
      ck("t4_stall_data",  32'(o_data),  32'(8'h40 + i));
      cyc();
    end
    o_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      ck("t4_drain_ack",  32'(ack),  32'b0010);
      ck("t4_drain_busy", 32'(busy), 32'd1);
      cyc();
    end
    ck("t4_done_busy", 32'(busy), 32'd0);

    // Test 5: requester 3 drops after two transfers; requester 0 is next.
    do_reset(4'b1000, 4'b0000);
    cyc();
    req = 4'b1001;
    #1;
    for (int i = 0; i < 2; i++) begin
      ck("t5_sel", 32'(sel), 32'd3);
      ck("t5_ack", 32'(ack), 32'b1000);
      cyc();
    end
    req = 4'b0001;
    #1;
    ck("t5_drop_valid", 32'(o_valid), 32'd0);
    ck("t5_drop_ack",   32'(ack),     32'd0);
    ck("t5_drop_busy",  32'(busy),    32'd1);
    cyc();
    ck("t5_idle_busy", 32'(busy), 32'd0);
    cyc();
    ck("t5_next_sel", 32'(sel), 32'd0);
    ck("t5_next_ack", 32'(ack), 32'b0001);

    // Test 6: reset mid-burst drops the word and restarts arbitration.
    do_reset(4'b0100, 4'b0000);
    cyc();
    cyc();
    cyc();
    ck("t6_mid_sel", 32'(sel), 32'd2);
    ck("t6_mid_ack", 32'(ack), 32'b0100);
    rst = 1'b1;
    #1;
    ck("t6_rst_ack", 32'(ack), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    ck("t6_after_sel",   32'(sel),     32'd0);
    ck("t6_after_busy",  32'(busy),    32'd0);
    ck("t6_after_valid", 32'(o_valid), 32'd0);
    ck("t6_after_ack",   32'(ack),     32'd0);
    ck("t6_after_data",  32'(o_data),  32'h11);
    req = 4'b1111;
    cyc();
    ck("t6_restart_sel", 32'(sel), 32'd0);
    ck("t6_restart_ack", 32'(ack), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
